// File: rtl/cfi_log_queue_pkg.sv
// Shared CFI trace types for the commit-side log queue and its backend.
// Holds the record layout, queue defaults and the full-queue handling mode.
package cfi_log_queue_pkg;

    typedef enum logic [1:0] {
        CFI_CALL   = 2'd0,
        CFI_RET    = 2'd1,
        CFI_JUMP   = 2'd2,
        CFI_BRANCH = 2'd3
    } cfi_kind_e;

    typedef struct packed {
        cfi_kind_e   kind;
        logic [31:0] pc;
        logic [31:0] target;
    } cfi_log_t;

    typedef enum logic {
        DROP_MODE_BACKPRESSURE = 1'b0,
        DROP_MODE_LOSSY        = 1'b1
    } drop_mode_e;

    localparam int unsigned CFI_QUEUE_DEPTH = 8;
    localparam int unsigned CFI_DROP_CNT_W  = 16;

    function automatic drop_mode_e drop_mode(input bit drop_on_full);
        return drop_on_full ? DROP_MODE_LOSSY : DROP_MODE_BACKPRESSURE;
    endfunction

endpackage

// File: rtl/cfi_queue_stats.sv
// Drop accounting for the lossy log queue: saturating drop counter plus a
// sticky overflow flag. Only rst_i clears either; queue flushes leave them.
module cfi_queue_stats #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             drop_i,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             overflow_o
);

    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (drop_i) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign drop_cnt_o = r_drop_cnt;
    assign overflow_o = r_overflow;

endmodule

// File: rtl/cfi_log_queue.sv
// First-word-fall-through queue of CFI trace records between the commit-side
// tracer and cfi_backend; head stays stable until popped or flushed.
module cfi_log_queue
    import cfi_log_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = CFI_QUEUE_DEPTH,
    parameter bit          DROP_ON_FULL = 1'b0,
    parameter int unsigned DROP_CNT_W   = CFI_DROP_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   log_valid_i,
    input  cfi_log_t               log_i,
    output logic                   log_ready_o,
    output cfi_log_t               log_o,
    output logic                   queue_empty_o,
    output logic                   queue_full_o,
    input  logic                   queue_pop_i,
    output logic [$clog2(DEPTH):0] usage_o,
    output logic [DROP_CNT_W-1:0]  drop_cnt_o,
    output logic                   overflow_o
);

    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam int unsigned        CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
    localparam drop_mode_e         MODE     = drop_mode(DROP_ON_FULL);

    cfi_log_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Status is decoded from the registered count only, so ready never sees pop.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_push  = log_valid_i && !w_full && !flush_i;
    assign w_pop   = queue_pop_i && !w_empty && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the record array has no reset; log_o is masked while empty, so stale slots never leak out.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= log_i;
        end
    end

    // A push lands in a slot other than rd_ptr unless the queue is empty, keeping the head stable.
    assign log_o         = w_empty ? '0 : r_mem[r_rd_ptr];
    assign queue_empty_o = w_empty;
    assign queue_full_o  = w_full;
    assign usage_o       = r_count;

    generate
        if (MODE == DROP_MODE_LOSSY) begin : g_lossy
            logic w_drop;

            assign w_drop      = log_valid_i && w_full && !flush_i;
            assign log_ready_o = 1'b1;

            cfi_queue_stats #(
                .CNT_W (DROP_CNT_W)
            ) u_stats (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .drop_i     (w_drop),
                .drop_cnt_o (drop_cnt_o),
                .overflow_o (overflow_o)
            );
        end else begin : g_backpressure
            assign log_ready_o = !w_full;
            assign drop_cnt_o  = '0;
            assign overflow_o  = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cfi_log_queue.sv
// Bench for cfi_log_queue: a backpressure and a lossy instance share one
// stimulus stream and are checked against one scoreboard queue.
module tb_cfi_log_queue;
    import cfi_log_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DCW   = 16;
    localparam int          SAT   = 65535;

    logic     clk = 1'b0;
    logic     rst;
    logic     flush;
    logic     valid;
    cfi_log_t din;
    logic     pop;

    logic     bp_ready, bp_empty, bp_full, bp_ovf;
    cfi_log_t bp_head;
    logic [3:0]     bp_usage;
    logic [DCW-1:0] bp_drop;

    logic     dr_ready, dr_empty, dr_full, dr_ovf;
    cfi_log_t dr_head;
    logic [3:0]     dr_usage;
    logic [DCW-1:0] dr_drop;

    cfi_log_t exp_q[$];
    int       exp_drop;
    logic     exp_ovf;
    int       n_checks = 0;
    int       n_fail   = 0;

    always #5 clk = ~clk;

    cfi_log_queue #(.DEPTH(DEPTH), .DROP_ON_FULL(1'b0), .DROP_CNT_W(DCW)) u_bp (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .log_valid_i(valid), .log_i(din),
        .log_ready_o(bp_ready), .log_o(bp_head), .queue_empty_o(bp_empty),
        .queue_full_o(bp_full), .queue_pop_i(pop), .usage_o(bp_usage),
        .drop_cnt_o(bp_drop), .overflow_o(bp_ovf)
    );

    cfi_log_queue #(.DEPTH(DEPTH), .DROP_ON_FULL(1'b1), .DROP_CNT_W(DCW)) u_dr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .log_valid_i(valid), .log_i(din),
        .log_ready_o(dr_ready), .log_o(dr_head), .queue_empty_o(dr_empty),
        .queue_full_o(dr_full), .queue_pop_i(pop), .usage_o(dr_usage),
        .drop_cnt_o(dr_drop), .overflow_o(dr_ovf)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cfi_log_t mk(input int i);
        cfi_log_t r;
        logic [31:0] iv;
        iv       = 32'(i);
        r.kind   = cfi_kind_e'(iv[1:0]);
        r.pc     = 32'h0000_1000 + (iv << 2);
        r.target = 32'h8000_0000 ^ iv;
        return r;
    endfunction

    task automatic check_state(input string tag);
        cfi_log_t eh;
        int n;
        n  = exp_q.size();
        eh = '0;
        if (n != 0) eh = exp_q[0];
        check({tag, ".bp_usage"}, bp_usage, n);
        check({tag, ".dr_usage"}, dr_usage, n);
        check({tag, ".bp_empty"}, bp_empty, n == 0);
        check({tag, ".dr_empty"}, dr_empty, n == 0);
        check({tag, ".bp_full"},  bp_full,  n == DEPTH);
        check({tag, ".dr_full"},  dr_full,  n == DEPTH);
        check({tag, ".bp_head"},  bp_head,  eh);
        check({tag, ".dr_head"},  dr_head,  eh);
        check({tag, ".bp_ready"}, bp_ready, n != DEPTH);
        check({tag, ".dr_ready"}, dr_ready, 1);
        check({tag, ".bp_drop"},  bp_drop,  0);
        check({tag, ".dr_drop"},  dr_drop,  exp_drop);
        check({tag, ".bp_ovf"},   bp_ovf,   0);
        check({tag, ".dr_ovf"},   dr_ovf,   exp_ovf);
    endtask

    // One clock of stimulus; pops compare the DUT head against the scoreboard front.
    task automatic step(input logic v, input cfi_log_t d, input logic p, input logic f);
        logic full_now, empty_now;
        full_now  = (exp_q.size() == DEPTH);
        empty_now = (exp_q.size() == 0);
        valid = v;
        din   = d;
        pop   = p;
        flush = f;
        if (p && !empty_now && !f) begin
            check("pop_head.bp", bp_head, exp_q[0]);
            check("pop_head.dr", dr_head, exp_q[0]);
        end
        @(posedge clk);
        #1;
        if (f) begin
            exp_q.delete();
        end else begin
            if (p && !empty_now) void'(exp_q.pop_front());
            if (v && !full_now) exp_q.push_back(d);
            if (v && full_now) begin
                exp_ovf = 1'b1;
                if (exp_drop < SAT) exp_drop++;
            end
        end
        valid = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        din   = '0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        exp_ovf  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; pop = 1'b0; din = '0;
        do_reset(2);
        check_state("reset");

        // Fill/drain with a ninth valid while full.
        for (int i = 1; i <= 8; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        check_state("full");
        step(1'b1, mk(9), 1'b0, 1'b0);
        check_state("ninth");
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_state("drained");
        step(1'b0, '0, 1'b1, 1'b0);
        check_state("pop_empty");

        // Backend holds the head across a long transfer.
        step(1'b1, mk(20), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check_state("hold");
            step(1'b0, '0, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check_state("hold_pop");

        // Simultaneous push and pop: mid, full, empty.
        for (int i = 30; i < 33; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        step(1'b1, mk(33), 1'b1, 1'b0);
        check_state("simul_mid");
        for (int i = 34; i < 39; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        check_state("simul_prefull");
        step(1'b1, mk(39), 1'b1, 1'b0);
        check_state("simul_full");
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_state("simul_drained");
        step(1'b1, mk(40), 1'b1, 1'b0);
        check_state("simul_empty");
        step(1'b0, '0, 1'b1, 1'b0);

        // Reset with records queued.
        for (int i = 41; i < 44; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        do_reset(1);
        check_state("mid_reset");

        // Lossy mode: five drops, contents untouched.
        for (int i = 50; i < 58; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        for (int i = 60; i < 65; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        check("drop5.cnt", dr_drop, 5);
        check("drop5.ovf", dr_ovf, 1);
        check_state("drop5");
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_state("drop5_drained");

        // Flush beats a same-cycle push and leaves drop stats alone.
        for (int i = 70; i < 75; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        check_state("preflush");
        step(1'b1, mk(75), 1'b0, 1'b1);
        check("flush.drop", dr_drop, 5);
        check_state("flush");
        step(1'b1, mk(76), 1'b0, 1'b0);
        check_state("postflush");
        step(1'b0, '0, 1'b1, 1'b0);

        // Saturate the drop counter.
        for (int i = 80; i < 88; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) step(1'b1, mk(i), 1'b0, 1'b0);
        check("sat.cnt", dr_drop, 16'hFFFF);
        check_state("sat");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
